// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if: LED target pattern in, PWM drive and per-channel fade status out.
interface led_pwm_fader_if;
    logic [1:0] led_in;
    logic [1:0] led_out;
    logic [1:0] busy;
    modport master (output led_in, input led_out, busy);
    modport slave  (input led_in, output led_out, busy);
endinterface

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: two-channel LED PWM driver with glitch-free duty updates and optional
// linear fade ramps between off and MAX_DUTY, enabled by defining LED_FADE_EN.
module led_pwm_fader #(
    parameter int PWM_DIV   = 10,
    parameter int PWM_STEPS = 100,
    parameter int MAX_DUTY  = 100,
    parameter int FADE_TICK = 25000
) (
    input logic             sys_clk,
    input logic             sys_rst_n,
    led_pwm_fader_if.slave  bus
);
    localparam int PW = $clog2(PWM_DIV + 1);
    localparam int CW = $clog2(PWM_STEPS + 1);
    localparam logic [1:0] OFF = 2'd0;
    localparam logic [1:0] ON  = 2'd2;
    localparam logic [CW-1:0] MAXD = CW'(MAX_DUTY);

    logic [1:0]    tgt;
    logic [PW-1:0] pre;
    logic [CW-1:0] pwm_cnt;
    logic [CW-1:0] ramp [2];
    logic [CW-1:0] ramp_nxt [2];
    logic [CW-1:0] shadow [2];
    logic [1:0]    state [2];
    logic [1:0]    state_nxt [2];
    logic          pre_wrap, period_wrap;

    assign pre_wrap    = pre == PW'(PWM_DIV - 1);
    assign period_wrap = pre_wrap && pwm_cnt == CW'(PWM_STEPS - 1);

`ifdef LED_FADE_EN
    localparam int TW = $clog2(FADE_TICK + 1);
    localparam logic [1:0] FADE_UP   = 2'd1;
    localparam logic [1:0] FADE_DOWN = 2'd3;

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = tick_cnt == TW'(FADE_TICK - 1);

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) tick_cnt <= '0;
        else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

    // A reversal that lands on an end stop settles directly instead of a one-cycle detour.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            case (state[i])
                OFF:     state_nxt[i] = tgt[i] ? FADE_UP : OFF;
                FADE_UP: state_nxt[i] = !tgt[i] ? (ramp[i] == '0 ? OFF : FADE_DOWN)
                                                : (ramp[i] == MAXD ? ON : FADE_UP);
                ON:      state_nxt[i] = tgt[i] ? ON : FADE_DOWN;
                default: state_nxt[i] = tgt[i] ? (ramp[i] == MAXD ? ON : FADE_UP)
                                               : (ramp[i] == '0 ? OFF : FADE_DOWN);
            endcase
            ramp_nxt[i] = !tick ? ramp[i]
                        : (state_nxt[i] == FADE_UP && ramp[i] != MAXD) ? ramp[i] + 1'b1
                        : (state_nxt[i] == FADE_DOWN && ramp[i] != '0) ? ramp[i] - 1'b1
                        : ramp[i];
        end
    end

    assign bus.busy = {state[1] == FADE_UP || state[1] == FADE_DOWN,
                       state[0] == FADE_UP || state[0] == FADE_DOWN};
`else
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = tgt[i] ? ON : OFF;
            ramp_nxt[i]  = tgt[i] ? MAXD : '0;
        end
    end

    assign bus.busy = 2'b00;
`endif

    // Shadow follows ramp only at the period boundary so a period never sees two duties.
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            tgt         <= '0;
            pre         <= '0;
            pwm_cnt     <= '0;
            bus.led_out <= '0;
            for (int i = 0; i < 2; i++) begin
                state[i]  <= OFF;
                ramp[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            tgt     <= bus.led_in;
            pre     <= pre_wrap ? '0 : pre + 1'b1;
            pwm_cnt <= period_wrap ? '0 : pre_wrap ? pwm_cnt + 1'b1 : pwm_cnt;
            for (int i = 0; i < 2; i++) begin
                state[i]       <= state_nxt[i];
                ramp[i]        <= ramp_nxt[i];
                shadow[i]      <= period_wrap ? ramp[i] : shadow[i];
                bus.led_out[i] <= pwm_cnt < shadow[i];
            end
        end
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: randomized and directed stimulus checked every cycle against a
// cycle-count based reference of the LED fader; follows LED_FADE_EN like the design.
module tb_led_pwm_fader;
    localparam int DIV   = 2;
    localparam int STEPS = 10;
    localparam int MAX   = 8;
    localparam int FT    = 5;
    localparam int PER   = DIV * STEPS;
`ifdef LED_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    led_pwm_fader_if bus ();

    led_pwm_fader #(.PWM_DIV(DIV), .PWM_STEPS(STEPS), .MAX_DUTY(MAX), .FADE_TICK(FT)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int m_n;
    logic [1:0] m_tgt, m_busy, m_led;
    int m_ramp [2];
    int m_shadow [2];

    function automatic int goal(logic t);
        return t ? MAX : 0;
    endfunction

    function automatic int toward(int r, int g);
        return r < g ? r + 1 : r > g ? r - 1 : r;
    endfunction

    // Reference: counters are n mod period arithmetic; a ramp walks one step per tick
    // toward its goal, and a channel is busy whenever its ramp is not yet at the goal.
    always @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            m_n    <= 0;
            m_tgt  <= '0;
            m_busy <= '0;
            m_led  <= '0;
            for (int i = 0; i < 2; i++) begin
                m_ramp[i]   <= 0;
                m_shadow[i] <= 0;
            end
        end else begin
            m_n   <= m_n + 1;
            m_tgt <= bus.led_in;
            for (int i = 0; i < 2; i++) begin
                m_busy[i]   <= FADE && (m_ramp[i] != goal(m_tgt[i]));
                m_ramp[i]   <= !FADE ? goal(m_tgt[i])
                             : (m_n % FT == FT - 1) ? toward(m_ramp[i], goal(m_tgt[i])) : m_ramp[i];
                m_shadow[i] <= (m_n % PER == PER - 1) ? m_ramp[i] : m_shadow[i];
                m_led[i]    <= ((m_n / DIV) % STEPS) < m_shadow[i];
            end
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int k);
        repeat (k) begin
            @(negedge sys_clk);
            chk("led_out", 32'(bus.led_out), 32'(m_led));
            chk("busy", 32'(bus.busy), 32'(m_busy));
        end
    endtask

    task automatic duty(input int ch, input int want);
        int cnt = 0;
        repeat (PER) begin
            @(negedge sys_clk);
            cnt += int'(bus.led_out[ch]);
        end
        chk($sformatf("duty_ch%0d", ch), cnt, want);
    endtask

    task automatic wait_lit(input int ch);
        int k = 0;
        while (bus.led_out[ch] !== 1'b1 && k < PER) begin
            @(negedge sys_clk);
            k++;
        end
        chk("wait_lit", 32'(bus.led_out[ch]), 1);
    endtask

    initial begin
        bus.led_in = 2'b01;
        #2;
        chk("rst_led", 32'(bus.led_out), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        #21 sys_rst_n = 1'b1;
        cycles(3);
        chk("start_busy", 32'(bus.busy), FADE ? 1 : 0);
        cycles(120);
        duty(0, MAX * DIV);
        duty(1, 0);
        bus.led_in = 2'b00;
        cycles(4 * FT + 3);
        bus.led_in = 2'b01;
        cycles(2 * FT);
        bus.led_in = 2'b00;
        cycles(120);
        duty(0, 0);
        bus.led_in = 2'b01;
        cycles(120);
        bus.led_in = 2'b10;
        cycles(3);
        chk("xfade_busy", 32'(bus.busy), FADE ? 3 : 0);
        cycles(120);
        duty(0, 0);
        duty(1, MAX * DIV);
        wait_lit(1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(bus.led_out), 0);
        chk("async_rst_busy", 32'(bus.busy), 0);
        bus.led_in = 2'b11;
        #7 sys_rst_n = 1'b1;
        cycles(3 * FT);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("midfade_rst_led", 32'(bus.led_out), 0);
        chk("midfade_rst_busy", 32'(bus.busy), 0);
        bus.led_in = 2'b00;
        #7 sys_rst_n = 1'b1;
        cycles(40);
        repeat (60) begin
            bus.led_in = 2'($urandom);
            cycles(int'($urandom_range(1, 70)));
        end
        bus.led_in = 2'b11;
        cycles(150);
        duty(0, MAX * DIV);
        duty(1, MAX * DIV);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
